// File: rtl/mii_tx.sv
// MII transmit framer: byte stream in, preamble/SFD/data/pad/FCS nibbles out, then inter-frame gap.
// Every output is a flop whose next value is derived from the next state.
module mii_tx #(
    parameter int MIN_PAYLOAD = 60,
    parameter bit PAD_EN      = 1'b1,
    parameter bit FCS_EN      = 1'b1,
    parameter int IFG_CLKS    = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_d,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       mii_en,
    output logic [3:0] mii_d,
    output logic       mii_er,
    output logic       busy,
    output logic       underrun
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_FCS  = 3'd5;
    localparam logic [2:0] S_IFG  = 3'd6;
    localparam logic [2:0] S_UNDR = 3'd7;   // two clocks of TX_ER after the source starved

    localparam logic [2:0] S_TAIL = FCS_EN ? S_FCS : S_IFG;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        nib_q, nib_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_last_q, hold_last_d;
    logic        fin_q, fin_d;
    logic [10:0] count_q, count_d;
    logic [31:0] crc_q, crc_d;
    logic        tx_ready_q, tx_ready_d;
    logic        mii_en_q, mii_en_d;
    logic [3:0]  mii_d_q, mii_d_d;
    logic        mii_er_q, mii_er_d;
    logic        busy_q, busy_d;
    logic        underrun_q, underrun_d;
    logic [31:0] fcs;
    logic        short_frame;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign short_frame = PAD_EN && (int'(count_q) < MIN_PAYLOAD);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nib_d       = nib_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        fin_d       = fin_q;
        count_d     = count_q;
        crc_d       = crc_q;

        case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    hold_d      = tx_d;
                    hold_last_d = tx_last;
                    count_d     = 11'd0;
                    crc_d       = 32'hFFFF_FFFF;
                    state_d     = S_PRE;
                    cnt_d       = 16'd0;
                end
            end
            S_PRE: begin
                if (cnt_q == 16'd13) begin
                    state_d = S_SFD;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SFD: begin
                if (cnt_q == 16'd1) begin
                    state_d = S_DATA;
                    nib_d   = 1'b0;
                end else begin
                    cnt_d = 16'd1;
                end
            end
            S_DATA: begin
                if (!nib_q) begin
                    // Byte is folded in on its low-nibble edge because hold may be reloaded here.
                    crc_d   = crc_byte(crc_q, hold_q);
                    count_d = (count_q == 11'h7FF) ? count_q : count_q + 11'd1;
                    fin_d   = hold_last_q;
                    nib_d   = 1'b1;
                    if (tx_ready_q) begin
                        if (tx_valid) begin
                            hold_d      = tx_d;
                            hold_last_d = tx_last;
                        end else begin
                            state_d = S_UNDR;
                            cnt_d   = 16'd0;
                        end
                    end
                end else if (fin_q) begin
                    state_d = short_frame ? S_PAD : S_TAIL;
                    cnt_d   = 16'd0;
                    nib_d   = 1'b0;
                end else begin
                    nib_d = 1'b0;
                end
            end
            S_PAD: begin
                if (!nib_q) begin
                    crc_d   = crc_byte(crc_q, 8'h00);
                    count_d = (count_q == 11'h7FF) ? count_q : count_q + 11'd1;
                    nib_d   = 1'b1;
                end else if (!short_frame) begin
                    state_d = S_TAIL;
                    cnt_d   = 16'd0;
                    nib_d   = 1'b0;
                end else begin
                    nib_d = 1'b0;
                end
            end
            S_FCS: begin
                if (cnt_q == 16'd7) begin
                    state_d = S_IFG;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_UNDR: begin
                if (cnt_q == 16'd1) begin
                    state_d = S_IFG;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = 16'd1;
                end
            end
            S_IFG: begin
                if (cnt_q == 16'(IFG_CLKS - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        tx_ready_d = 1'b0;
        mii_en_d   = 1'b0;
        mii_d_d    = 4'h0;
        mii_er_d   = 1'b0;
        underrun_d = 1'b0;
        busy_d     = (state_d != S_IDLE);
        fcs        = ~crc_d;

        case (state_d)
            S_IDLE: tx_ready_d = 1'b1;
            S_PRE: begin
                mii_en_d = 1'b1;
                mii_d_d  = 4'h5;
            end
            S_SFD: begin
                mii_en_d = 1'b1;
                mii_d_d  = (cnt_d == 16'd0) ? 4'h5 : 4'hD;
            end
            S_DATA: begin
                mii_en_d   = 1'b1;
                mii_d_d    = nib_d ? hold_q[7:4] : hold_q[3:0];
                tx_ready_d = !nib_d && !hold_last_d;
            end
            S_PAD: mii_en_d = 1'b1;
            S_FCS: begin
                mii_en_d = 1'b1;
                mii_d_d  = fcs[{cnt_d[2:0], 2'b00} +: 4];
            end
            S_UNDR: begin
                mii_en_d   = 1'b1;
                mii_er_d   = 1'b1;
                underrun_d = (state_q != S_UNDR);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            nib_q       <= 1'b0;
            hold_q      <= 8'h00;
            hold_last_q <= 1'b0;
            fin_q       <= 1'b0;
            count_q     <= 11'd0;
            crc_q       <= 32'hFFFF_FFFF;
            tx_ready_q  <= 1'b0;
            mii_en_q    <= 1'b0;
            mii_d_q     <= 4'h0;
            mii_er_q    <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nib_q       <= nib_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            fin_q       <= fin_d;
            count_q     <= count_d;
            crc_q       <= crc_d;
            tx_ready_q  <= tx_ready_d;
            mii_en_q    <= mii_en_d;
            mii_d_q     <= mii_d_d;
            mii_er_q    <= mii_er_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign mii_en   = mii_en_q;
    assign mii_d    = mii_d_q;
    assign mii_er   = mii_er_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_mii_tx.sv
// Directed bench for mii_tx: one default instance and one with padding disabled, sharing stimulus.
module tb_mii_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset    = 1'b0;
    logic [7:0] tx_d     = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last  = 1'b0;
    logic       sel      = 1'b0;

    logic       rdy_a, en_a, er_a, busy_a, und_a;
    logic [3:0] d_a;
    logic       rdy_b, en_b, er_b, busy_b, und_b;
    logic [3:0] d_b;
    logic       rdy, en, er, busy, und;
    logic [3:0] dn;

    assign rdy  = sel ? rdy_b  : rdy_a;
    assign en   = sel ? en_b   : en_a;
    assign er   = sel ? er_b   : er_a;
    assign busy = sel ? busy_b : busy_a;
    assign und  = sel ? und_b  : und_a;
    assign dn   = sel ? d_b    : d_a;

    mii_tx dut_a (
        .clk(clk), .reset(reset), .tx_d(tx_d), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(rdy_a), .mii_en(en_a), .mii_d(d_a), .mii_er(er_a), .busy(busy_a), .underrun(und_a)
    );

    mii_tx #(.PAD_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .tx_d(tx_d), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(rdy_b), .mii_en(en_b), .mii_d(d_b), .mii_er(er_b), .busy(busy_b), .underrun(und_b)
    );

    localparam int NC = 400;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] fb [0:127];
    logic       fl [0:127];
    logic       log_en [NC];
    logic       log_er [NC];
    logic       log_und [NC];
    logic       log_rdy [NC];
    logic       log_busy [NC];
    logic       log_hs [NC];
    logic [3:0] log_d [NC];
    logic [3:0] exp_d [NC];
    logic [3:0] fcs_hand [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fbit;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fbit = r[0] ^ b[i];
            r    = {1'b0, r[31:1]};
            if (fbit) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic do_reset();
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives bytes fb[0..n-1] as fast as tx_ready allows, stopping at drop_at, logging ncyc clocks.
    task automatic run(input int n, input int drop_at, input int ncyc);
        int   idx;
        logic hs, r_prev, v_prev;
        idx      = 0;
        tx_d     = fb[0];
        tx_last  = fl[0];
        tx_valid = 1'b1;
        r_prev   = rdy;
        v_prev   = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            hs          = r_prev & v_prev;
            log_en[c]   = en;
            log_er[c]   = er;
            log_und[c]  = und;
            log_rdy[c]  = rdy;
            log_busy[c] = busy;
            log_hs[c]   = hs;
            log_d[c]    = dn;
            if (hs) idx++;
            if (idx >= n || idx == drop_at) begin
                tx_valid = 1'b0;
            end else begin
                tx_valid = 1'b1;
                tx_d     = fb[idx];
                tx_last  = fl[idx];
            end
            r_prev = rdy;
            v_prev = tx_valid;
        end
        tx_valid = 1'b0;
    endtask

    task automatic build(input int off, input int n, input bit pad, output int len);
        logic [31:0] crc;
        logic [31:0] f;
        int          k, cnt;
        k = 0;
        for (int i = 0; i < 15; i++) begin
            exp_d[k] = 4'h5;
            k++;
        end
        exp_d[k] = 4'hD;
        k++;
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            exp_d[k]     = fb[off + i][3:0];
            exp_d[k + 1] = fb[off + i][7:4];
            k            = k + 2;
            crc          = crc_upd(crc, fb[off + i]);
        end
        cnt = n;
        while (pad && cnt < 60) begin
            exp_d[k]     = 4'h0;
            exp_d[k + 1] = 4'h0;
            k            = k + 2;
            crc          = crc_upd(crc, 8'h00);
            cnt++;
        end
        f = ~crc;
        for (int j = 0; j < 8; j++) begin
            exp_d[k] = f[4 * j +: 4];
            k++;
        end
        len = k;
    endtask

    function automatic int run_len(input int s, input logic lvl);
        int k;
        k = 0;
        while (s + k < NC && log_en[s + k] == lvl) k++;
        return k;
    endfunction

    task automatic cmp_stream(input string tag, input int start, input int len);
        int errs;
        errs = 0;
        for (int i = 0; i < len; i++) begin
            if (log_d[start + i] !== exp_d[i] || log_en[start + i] !== 1'b1 || log_er[start + i] !== 1'b0)
                errs++;
        end
        check(tag, errs, 0);
    endtask

    task automatic chk_ifg(input int e);
        int low;
        low = 0;
        for (int i = e; i < e + 24; i++) if (log_en[i] == 1'b0 && log_d[i] == 4'h0) low++;
        check("ifg_low_clks", low, 24);
        check("ifg_busy", 32'(log_busy[e + 12]), 32'd1);
        check("ifg_ready_low", 32'(log_rdy[e + 23]), 32'd0);
        check("idle_ready", 32'(log_rdy[e + 24]), 32'd1);
        check("idle_not_busy", 32'(log_busy[e + 24]), 32'd0);
    endtask

    initial begin
        int len, errs, hsn;
        fcs_hand = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        for (int i = 0; i < 128; i++) fl[i] = 1'b0;

        // 1: reset mid-preamble
        sel = 1'b0;
        do_reset();
        check("rst_idle_ready", 32'(rdy), 32'd1);
        check("rst_idle_busy", 32'(busy), 32'd0);
        tx_d = 8'h11; tx_last = 1'b1; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("pre_en_latency1", 32'(en), 32'd1);
        check("pre_nibble", 32'(dn), 32'h5);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_mii_en", 32'(en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(rdy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", 32'(rdy), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);
        errs = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (en !== 1'b0) errs++;
        end
        check("rst_no_resume", errs, 0);

        // 2: "123456789", no padding
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            fb[i] = 8'h31 + 8'(i);
            fl[i] = (i == 8);
        end
        run(9, -1, 100);
        check("t2_en_len", run_len(0, 1'b1), 42);
        check("t2_d16", 32'(log_d[16]), 32'h1);
        check("t2_d17", 32'(log_d[17]), 32'h3);
        for (int j = 0; j < 8; j++) check("t2_fcs_nib", 32'(log_d[34 + j]), 32'(fcs_hand[j]));
        build(0, 9, 1'b0, len);
        cmp_stream("t2_stream_errs", 0, len);
        chk_ifg(42);
        fl[8] = 1'b0;

        // 3: 18-byte frame padded to 60
        sel = 1'b0;
        do_reset();
        fb[0] = 8'h54; fb[1] = 8'hFF; fb[2] = 8'h01; fb[3] = 8'h21; fb[4] = 8'h23; fb[5] = 8'h24;
        fb[6] = 8'h12; fb[7] = 8'h34; fb[8] = 8'h56; fb[9] = 8'h78; fb[10] = 8'h9A; fb[11] = 8'hBC;
        fb[12] = 8'h12; fb[13] = 8'h34; fb[14] = 8'hDE; fb[15] = 8'hAD; fb[16] = 8'hBE; fb[17] = 8'hEF;
        fl[17] = 1'b1;
        run(18, -1, 200);
        check("t3_en_len", run_len(0, 1'b1), 144);
        build(0, 18, 1'b1, len);
        check("t3_build_len", len, 144);
        cmp_stream("t3_stream_errs", 0, len);
        chk_ifg(144);
        fl[17] = 1'b0;

        // 4: 64 bytes streamed without bubbles
        do_reset();
        for (int i = 0; i < 64; i++) fb[i] = 8'(i * 3 + 7);
        fl[63] = 1'b1;
        run(64, -1, 200);
        check("t4_en_len", run_len(0, 1'b1), 152);
        hsn  = 0;
        errs = 0;
        for (int c = 0; c < 200; c++) if (log_hs[c]) hsn++;
        for (int k = 1; k < 64; k++) if (log_hs[15 + 2 * k] !== 1'b1) errs++;
        check("t4_hs_count", hsn, 64);
        check("t4_hs_spacing_errs", errs, 0);
        build(0, 64, 1'b1, len);
        cmp_stream("t4_stream_errs", 0, len);
        chk_ifg(152);
        fl[63] = 1'b0;

        // 5: source starves after 20 bytes
        do_reset();
        run(64, 20, 120);
        build(0, 20, 1'b0, len);
        cmp_stream("t5_prefix_errs", 0, 55);
        check("t5_en_len", run_len(0, 1'b1), 57);
        check("t5_er_before", 32'(log_er[54]), 32'd0);
        check("t5_er_1", 32'(log_er[55]), 32'd1);
        check("t5_er_2", 32'(log_er[56]), 32'd1);
        check("t5_d_zero", 32'({log_d[55], log_d[56]}), 32'd0);
        check("t5_underrun_pulse", 32'(log_und[55]), 32'd1);
        hsn = 0;
        for (int c = 0; c < 120; c++) if (log_und[c]) hsn++;
        check("t5_underrun_count", hsn, 1);
        check("t5_er_after", 32'(log_er[57]), 32'd0);
        chk_ifg(57);

        // 6: back-to-back frames with tx_valid held through the gap
        do_reset();
        for (int i = 0; i < 10; i++) fb[i] = 8'hC0 + 8'(i);
        fl[9]  = 1'b1;
        fb[10] = 8'hA5;
        fl[10] = 1'b1;
        run(11, -1, 400);
        check("t6_f1_len", run_len(0, 1'b1), 144);
        check("t6_gap", run_len(144, 1'b0), 25);
        check("t6_f2_hs", 32'(log_hs[169]), 32'd1);
        check("t6_f2_len", run_len(169, 1'b1), 144);
        build(10, 1, 1'b1, len);
        cmp_stream("t6_f2_stream_errs", 169, len);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
